// File: rtl/combiner_pkg.sv
// combiner_pkg: shared defaults and width helpers for the combiner block.
//   DEBOUNCE_CYCLES_DEF : default switch debounce hold time (clock cycles)
//   TRIG_WIDTH_DEF      : default trig1/trig2 pulse width (clock cycles)
//   DB_CNT_W            : debounce counter width for the default hold time
package combiner_pkg;

  localparam int DEBOUNCE_CYCLES_DEF = 16;
  localparam int TRIG_WIDTH_DEF      = 4;

  // Width of a counter that must hold values 0..max_count (never below 1 bit).
  function automatic int cnt_width(input int max_count);
    return (max_count < 1) ? 1 : $clog2(max_count + 1);
  endfunction

  localparam int DB_CNT_W = $clog2(DEBOUNCE_CYCLES_DEF + 1);

endpackage

// File: rtl/sync_debounce.sv
// sync_debounce: 1-bit two-flop synchronizer followed by a debouncer.
//   clk : system clock
//   rst : asynchronous active-high reset
//   din : asynchronous raw input
//   deb : accepted (debounced) value; changes only after the synchronized
//         input has differed from it for DEBOUNCE_CYCLES consecutive cycles
module sync_debounce
  import combiner_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic deb
);

  localparam int               CNT_W    = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             meta;
  logic             synced;
  logic [CNT_W-1:0] cnt;

  // Two-flop synchronizer for the raw input.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta   <= 1'b0;
      synced <= 1'b0;
    end else begin
      meta   <= din;
      synced <= meta;
    end
  end

  // Count consecutive cycles of disagreement; any agreement restarts the count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= {CNT_W{1'b0}};
      deb <= 1'b0;
    end else if (synced == deb) begin
      cnt <= {CNT_W{1'b0}};
    end else if (cnt == CNT_LAST) begin
      cnt <= {CNT_W{1'b0}};
      deb <= synced;
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/combiner.sv
// combiner: front-panel switch / PoE / trigger glue for the clock-trigger board.
//   osc_clk0         : system clock (all registers on its rising edge)
//   rst              : asynchronous active-high reset
//   osc_clk1         : alternate oscillator, pinout only
//   sma_clk          : external clock, fanned out combinationally
//   sma_trig         : external trigger (async), synchronized + pulse-stretched
//   switch[8:1]      : front-panel switches (async), [4:1] used
//   poe_vc_det[4:1]  : PoE voltage-detect per port (async)
//   poe_aux_det[4:1] : PoE aux-detect per port (async)
//   osc_sel, trig_sel, trig_en : debounced switch[1..3], registered
//   trig1, trig2     : TRIG_WIDTH-cycle trigger pulses, gated by switches
//   sma_trig_monitor : synchronized sma_trig, four copies
//   sma_clk_monitor  : sma_clk, four copies
//   poe_led[8:1]     : interleaved synchronized PoE detect bits
module combiner
  import combiner_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int TRIG_WIDTH      = TRIG_WIDTH_DEF
) (
  input  logic       osc_clk0,
  input  logic       rst,
  input  logic       osc_clk1,
  input  logic       sma_clk,
  input  logic       sma_trig,
  input  logic [8:1] switch,
  input  logic [4:1] poe_vc_det,
  input  logic [4:1] poe_aux_det,
  output logic       osc_sel,
  output logic       trig_sel,
  output logic       trig_en,
  output logic       trig1,
  output logic       trig2,
  output logic [4:1] sma_trig_monitor,
  output logic [4:1] sma_clk_monitor,
  output logic [8:1] poe_led
);

  localparam int            TW        = cnt_width(TRIG_WIDTH);
  localparam logic [TW-1:0] TRIG_LOAD = TW'(TRIG_WIDTH);

  logic [8:1]    sw_deb;
  logic [8:0]    in_meta;   // {sma_trig, poe_aux_det[4:1], poe_vc_det[4:1]}
  logic [8:0]    in_sync;
  logic          trig_s;
  logic          trig_prev;
  logic          trig_armed;
  logic [1:0]    flush;
  logic [TW-1:0] pulse_cnt;
  logic [TW-1:0] pulse_cnt_next;
  logic          rise;
  logic          pulse_next;
  logic          unused_inputs;

  genvar i;
  for (i = 1; i <= 8; i++) begin : g_sw
    sync_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_sw (
      .clk(osc_clk0),
      .rst(rst),
      .din(switch[i]),
      .deb(sw_deb[i])
    );
  end

  // switch[8:5] are reserved and osc_clk1 only exists for the pinout.
  assign unused_inputs   = ^{osc_clk1, sw_deb[8:5]};
  assign sma_clk_monitor = {4{sma_clk}};
  assign trig_s          = in_sync[8];

  // Two-flop synchronizers for the trigger and PoE detect inputs.
  always_ff @(posedge osc_clk0 or posedge rst) begin
    if (rst) begin
      in_meta <= 9'b0;
      in_sync <= 9'b0;
    end else begin
      in_meta <= {sma_trig, poe_aux_det, poe_vc_det};
      in_sync <= in_meta;
    end
  end

  // Edge-detect history. The synchronizer output is meaningless for two cycles
  // after reset, so edges are only honoured once a genuine low has been seen;
  // this keeps a trigger held high across reset from firing a pulse.
  always_ff @(posedge osc_clk0 or posedge rst) begin
    if (rst) begin
      flush      <= 2'b00;
      trig_prev  <= 1'b0;
      trig_armed <= 1'b0;
    end else begin
      flush      <= {flush[0], 1'b1};
      trig_prev  <= trig_s;
      trig_armed <= trig_armed | (flush[1] & ~trig_s);
    end
  end

  // Pulse counter: reloads only when idle, so edges inside a pulse are dropped.
  always_comb begin
    pulse_cnt_next = {TW{1'b0}};
    rise           = trig_s & ~trig_prev & trig_armed;
    if (pulse_cnt != {TW{1'b0}}) begin
      pulse_cnt_next = pulse_cnt - TW'(1);
    end else if (rise) begin
      pulse_cnt_next = TRIG_LOAD;
    end else begin
      pulse_cnt_next = {TW{1'b0}};
    end
    pulse_next = (pulse_cnt_next != {TW{1'b0}});
  end

  // Pulse counter register.
  always_ff @(posedge osc_clk0 or posedge rst) begin
    if (rst) begin
      pulse_cnt <= {TW{1'b0}};
    end else begin
      pulse_cnt <= pulse_cnt_next;
    end
  end

  // Registered outputs. Trigger gating uses the accepted switch values directly
  // so a falling enable blanks trig1/trig2 on the very next edge.
  always_ff @(posedge osc_clk0 or posedge rst) begin
    if (rst) begin
      osc_sel          <= 1'b0;
      trig_sel         <= 1'b0;
      trig_en          <= 1'b0;
      trig1            <= 1'b0;
      trig2            <= 1'b0;
      sma_trig_monitor <= 4'b0;
      poe_led          <= 8'b0;
    end else begin
      osc_sel          <= sw_deb[1];
      trig_sel         <= sw_deb[2];
      trig_en          <= sw_deb[3];
      trig1            <= pulse_next & sw_deb[3];
      trig2            <= pulse_next & sw_deb[3] & sw_deb[4];
      sma_trig_monitor <= {4{trig_s}};
      poe_led          <= {in_sync[7], in_sync[3], in_sync[6], in_sync[2],
                           in_sync[5], in_sync[1], in_sync[4], in_sync[0]};
    end
  end

endmodule

// File: tb/tb_combiner.sv
// tb_combiner: directed self-checking bench for combiner.
module tb_combiner;

  logic       osc_clk0 = 1'b0;
  logic       osc_clk1 = 1'b0;
  logic       rst;
  logic       sma_clk;
  logic       sma_trig;
  logic [8:1] switch;
  logic [4:1] poe_vc_det;
  logic [4:1] poe_aux_det;
  logic       osc_sel;
  logic       trig_sel;
  logic       trig_en;
  logic       trig1;
  logic       trig2;
  logic [4:1] sma_trig_monitor;
  logic [4:1] sma_clk_monitor;
  logic [8:1] poe_led;

  int checks   = 0;
  int failures = 0;

  combiner dut (
    .osc_clk0(osc_clk0),
    .rst(rst),
    .osc_clk1(osc_clk1),
    .sma_clk(sma_clk),
    .sma_trig(sma_trig),
    .switch(switch),
    .poe_vc_det(poe_vc_det),
    .poe_aux_det(poe_aux_det),
    .osc_sel(osc_sel),
    .trig_sel(trig_sel),
    .trig_en(trig_en),
    .trig1(trig1),
    .trig2(trig2),
    .sma_trig_monitor(sma_trig_monitor),
    .sma_clk_monitor(sma_clk_monitor),
    .poe_led(poe_led)
  );

  always #5 osc_clk0 = ~osc_clk0;
  always #7 osc_clk1 = ~osc_clk1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One rising edge, then park on the falling edge for driving/sampling.
  task automatic step(input int n);
    repeat (n) begin
      @(posedge osc_clk0);
      @(negedge osc_clk0);
    end
  endtask

  // Drive sma_trig bit k before edge k; check trig1/trig2/monitor after edge k.
  task automatic run_trig(input string tag, input logic [15:0] r,
                          input logic [15:0] exp1, input logic [15:0] exp2);
    for (int k = 1; k <= 15; k++) begin
      sma_trig = r[k];
      step(1);
      check($sformatf("%s_trig1_k%0d", tag, k), {31'b0, trig1}, {31'b0, exp1[k]});
      check($sformatf("%s_trig2_k%0d", tag, k), {31'b0, trig2}, {31'b0, exp2[k]});
      if (k >= 2)
        check($sformatf("%s_mon_k%0d", tag, k), {28'b0, sma_trig_monitor},
              {28'b0, {4{r[k-2]}}});
    end
  endtask

  initial begin
    rst = 1'b1; sma_clk = 1'b0; sma_trig = 1'b0;
    switch = 8'h00; poe_vc_det = 4'h0; poe_aux_det = 4'h0;
    @(negedge osc_clk0);

    // Reset held with inputs toggling: registered outputs stay 0.
    for (int k = 0; k < 4; k++) begin
      sma_clk = 1'b1;
      #1 check("rst_clkmon_hi", {28'b0, sma_clk_monitor}, 32'h0000000F);
      sma_clk = 1'b0;
      #1 check("rst_clkmon_lo", {28'b0, sma_clk_monitor}, 32'h00000000);
      switch = ~switch; sma_trig = ~sma_trig;
      poe_vc_det = ~poe_vc_det; poe_aux_det = ~poe_aux_det;
      step(1);
      check("rst_outs", {15'b0, osc_sel, trig_sel, trig_en, trig1, trig2,
                         sma_trig_monitor, poe_led}, 32'h0);
    end

    switch = 8'h00; sma_trig = 1'b0; poe_vc_det = 4'h0; poe_aux_det = 4'h0;
    rst = 1'b0;
    step(6);

    // Ten-cycle glitch on switch[1] is rejected.
    switch[1] = 1'b1;
    step(10);
    switch[1] = 1'b0;
    step(25);
    check("glitch_osc_sel", {31'b0, osc_sel}, 32'h0);

    // Held switch[1]: osc_sel rises after exactly 2+16+1 edges.
    switch[1] = 1'b1;
    for (int k = 1; k <= 22; k++) begin
      step(1);
      check($sformatf("osc_sel_k%0d", k), {31'b0, osc_sel}, {31'b0, (k >= 19)});
    end

    // PoE LED mapping and latency.
    poe_vc_det = 4'b0101; poe_aux_det = 4'b1010;
    step(2);
    check("poe_led_2cyc", {24'b0, poe_led}, 32'h00);
    step(1);
    check("poe_led_3cyc", {24'b0, poe_led}, 32'h99);

    // Settle switch[2..4].
    switch[4:2] = 3'b111;
    step(20);
    check("trig_sel_on", {31'b0, trig_sel}, 32'h1);
    check("trig_en_on", {31'b0, trig_en}, 32'h1);

    // Single rise: 4-cycle pulse starting 3 edges later.
    run_trig("single", 16'h007E, 16'h0078, 16'h0078);
    step(5);
    // Re-rise inside the pulse is ignored.
    run_trig("inpulse", 16'h01F2, 16'h0078, 16'h0078);
    step(5);
    // Rise in the first cycle after a pulse starts a new one.
    run_trig("b2b", 16'h00C2, 16'h0F78, 16'h0F78);
    step(5);

    // switch[4] off: only trig1 pulses.
    switch[4] = 1'b0;
    step(20);
    run_trig("no_sw4", 16'h007E, 16'h0078, 16'h0000);
    switch[4] = 1'b1;
    step(20);

    // trig_en drops mid-pulse: outputs blank on the next edge.
    switch[3] = 1'b0;
    for (int k = 1; k <= 24; k++) begin
      sma_trig = (k >= 14 && k <= 18);
      step(1);
      check($sformatf("en_drop_trig1_k%0d", k), {31'b0, trig1},
            {31'b0, (k >= 16 && k <= 18)});
      check($sformatf("en_drop_trig2_k%0d", k), {31'b0, trig2},
            {31'b0, (k >= 16 && k <= 18)});
      if (k == 18 || k == 19)
        check($sformatf("en_drop_trig_en_k%0d", k), {31'b0, trig_en}, {31'b0, (k == 18)});
    end
    step(4);

    // Triggers disabled: no pulses, monitor still follows.
    run_trig("disabled", 16'h007E, 16'h0000, 16'h0000);
    step(4);

    // Reset mid-pulse ends it at once; held trigger does not refire.
    switch[3] = 1'b1;
    step(20);
    sma_trig = 1'b1;
    step(3);
    check("pre_rst_trig1", {31'b0, trig1}, 32'h1);
    rst = 1'b1;
    #1 check("rst_mid_trig1", {31'b0, trig1}, 32'h0);
    check("rst_mid_poe", {24'b0, poe_led}, 32'h0);
    check("rst_mid_osc_sel", {31'b0, osc_sel}, 32'h0);
    step(2);
    rst = 1'b0;
    for (int k = 1; k <= 22; k++) begin
      step(1);
      check($sformatf("post_rst_trig1_k%0d", k), {31'b0, trig1}, 32'h0);
    end
    check("post_rst_trig_en", {31'b0, trig_en}, 32'h1);
    check("post_rst_mon", {28'b0, sma_trig_monitor}, 32'h0000000F);
    sma_trig = 1'b0;
    step(4);
    sma_trig = 1'b1;
    step(3);
    check("rearm_trig1", {31'b0, trig1}, 32'h1);
    sma_trig = 1'b0;
    step(6);
    check("rearm_trig1_end", {31'b0, trig1}, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
